// File: rtl/edge_capture_sampler.sv
// Multi-channel probe sampler: per-lane synchroniser and edge qualifier,
// shared gated history, sticky edge flags and a saturating edge counter.

// Per-channel synchroniser chain plus mode-qualified edge detect.
module edge_capture_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  input  logic       old,
  input  logic [1:0] mode,
  output logic       sync_out,
  output logic       new_edge
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rise, fall;

  // shift the raw pin into the chain every clock, independent of en
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // synchroniser flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // edge is only meaningful on a shift cycle, so gate it with en here
  always_comb begin
    rise     = sync_out & ~old;
    fall     = ~sync_out & old;
    new_edge = en & ((mode[0] & rise) | (mode[1] & fall));
  end
endmodule

module edge_capture_sampler #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HIST_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [2*WIDTH-1:0]          mode,
  input  logic                        clear,
  output logic [WIDTH-1:0]            now,
  output logic [WIDTH-1:0]            prev,
  output logic [WIDTH*HIST_DEPTH-1:0] hist_flat,
  output logic [WIDTH-1:0]            edge_pulse,
  output logic                        any_edge,
  output logic [WIDTH-1:0]            edge_sticky,
  output logic [CNT_W-1:0]            edge_count,
  output logic                        count_sat
);
  logic [WIDTH-1:0]                  sync_out, new_edge;
  logic [HIST_DEPTH-1:0][WIDTH-1:0]  hist_q, hist_d;
  logic [WIDTH-1:0]                  pulse_q, pulse_d;
  logic [WIDTH-1:0]                  sticky_q, sticky_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic                              any_new;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    edge_capture_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .din      (in_data[g]),
      .en       (en),
      .old      (hist_q[0][g]),
      .mode     (mode[2*g +: 2]),
      .sync_out (sync_out[g]),
      .new_edge (new_edge[g])
    );
  end

  // history shifts only on enabled cycles; pulse tracks the pair just loaded
  always_comb begin
    hist_d = hist_q;
    if (en) hist_d = {hist_q[HIST_DEPTH-2:0], sync_out};
    pulse_d = new_edge;
  end

  // sticky set wins over clear; counter counts edge cycles, not edges
  always_comb begin
    any_new  = |new_edge;
    sticky_d = (clear ? '0 : sticky_q) | new_edge;
    if (clear)                       count_d = any_new ? CNT_W'(1) : '0;
    else if (any_new && !(&count_q)) count_d = count_q + CNT_W'(1);
    else                             count_d = count_q;
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      hist_q   <= hist_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign now         = hist_q[0];
  assign prev        = hist_q[1];
  assign hist_flat   = hist_q;
  assign edge_pulse  = pulse_q;
  assign any_edge    = |pulse_q;
  assign edge_sticky = sticky_q;
  assign edge_count  = count_q;
  assign count_sat   = &count_q;
endmodule

// File: tb/tb_edge_capture_sampler.sv
module tb_edge_capture_sampler;
  localparam int W = 8, S = 2, D = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 0, rst = 1, en = 0, clear = 0;
  logic [W-1:0]   in_data = '0;
  logic [2*W-1:0] mode = '0;
  logic [W-1:0]   now, prev, edge_pulse, edge_sticky;
  logic [W*D-1:0] hist_flat;
  logic           any_edge, count_sat;
  logic [CW-1:0]  edge_count;

  edge_capture_sampler #(.WIDTH(W), .SYNC_STAGES(S), .HIST_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .mode(mode), .clear(clear),
    .now(now), .prev(prev), .hist_flat(hist_flat), .edge_pulse(edge_pulse),
    .any_edge(any_edge), .edge_sticky(edge_sticky), .edge_count(edge_count),
    .count_sat(count_sat)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model: inputs delayed by S clocks, then a plain history array
  logic [W-1:0]        m_q[$];
  logic [D-1:0][W-1:0] m_hist;
  logic [W-1:0]        m_pulse, m_sticky;
  int                  m_cnt;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < S; i++) m_q.push_back('0);
    m_hist = '0; m_pulse = '0; m_sticky = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] nw, ne;
    nw = m_q.pop_front();
    m_q.push_back(in_data);
    ne = '0;
    if (en) begin
      for (int i = 0; i < W; i++) begin
        if (mode[2*i]   && nw[i] && !m_hist[0][i]) ne[i] = 1'b1;
        if (mode[2*i+1] && !nw[i] && m_hist[0][i]) ne[i] = 1'b1;
      end
      m_hist = {m_hist[D-2:0], nw};
    end
    m_pulse = ne;
    if (clear) begin m_sticky = '0; m_cnt = 0; end
    m_sticky = m_sticky | ne;
    if (ne != '0 && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("now", now, m_hist[0]);
    chk("prev", prev, m_hist[1]);
    chk("hist_flat", hist_flat, m_hist);
    chk("edge_pulse", edge_pulse, m_pulse);
    chk("any_edge", any_edge, m_pulse != '0);
    chk("edge_sticky", edge_sticky, m_sticky);
    chk("edge_count", edge_count, m_cnt);
    chk("count_sat", count_sat, m_cnt == CMAX);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_now"}, now, 0);
    chk({tag, "_prev"}, prev, 0);
    chk({tag, "_hist"}, hist_flat, 0);
    chk({tag, "_pulse"}, edge_pulse, 0);
    chk({tag, "_any"}, any_edge, 0);
    chk({tag, "_sticky"}, edge_sticky, 0);
    chk({tag, "_count"}, edge_count, 0);
    chk({tag, "_sat"}, count_sat, 0);
  endtask

  // inputs are set at negedge; one rising edge; outputs sampled at next negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clear = 0; en = 0; in_data = '0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic [W-1:0]   din;
    logic           en;
    logic [2*W-1:0] mode;
    logic [W-1:0]   now, prev, pulse, sticky;
    int             cnt;
  } vec_t;
  vec_t tbl[15];

  initial begin
    // mode mix (ch0 rise, ch1 fall, ch2 both, ch3 off), latency, enable gating
    tbl[0]  = '{8'h0F, 1, 16'h0039, 8'h00, 8'h00, 8'h00, 8'h00, 0};
    tbl[1]  = '{8'h0F, 1, 16'h0039, 8'h00, 8'h00, 8'h00, 8'h00, 0};
    tbl[2]  = '{8'h00, 1, 16'h0039, 8'h0F, 8'h00, 8'h05, 8'h05, 1};
    tbl[3]  = '{8'h00, 1, 16'h0039, 8'h0F, 8'h0F, 8'h00, 8'h05, 1};
    tbl[4]  = '{8'h00, 1, 16'h0039, 8'h00, 8'h0F, 8'h06, 8'h07, 2};
    tbl[5]  = '{8'h00, 1, 16'h0039, 8'h00, 8'h00, 8'h00, 8'h07, 2};
    tbl[6]  = '{8'h01, 1, 16'h5555, 8'h00, 8'h00, 8'h00, 8'h07, 2};
    tbl[7]  = '{8'h01, 1, 16'h5555, 8'h00, 8'h00, 8'h00, 8'h07, 2};
    tbl[8]  = '{8'h01, 1, 16'h5555, 8'h01, 8'h00, 8'h01, 8'h07, 3};
    tbl[9]  = '{8'h01, 1, 16'h5555, 8'h01, 8'h01, 8'h00, 8'h07, 3};
    tbl[10] = '{8'hFF, 0, 16'h5555, 8'h01, 8'h01, 8'h00, 8'h07, 3};
    tbl[11] = '{8'hFF, 0, 16'h5555, 8'h01, 8'h01, 8'h00, 8'h07, 3};
    tbl[12] = '{8'hFF, 0, 16'h5555, 8'h01, 8'h01, 8'h00, 8'h07, 3};
    tbl[13] = '{8'hFF, 1, 16'h5555, 8'hFF, 8'h01, 8'hFE, 8'hFF, 4};
    tbl[14] = '{8'hFF, 1, 16'h5555, 8'hFF, 8'hFF, 8'h00, 8'hFF, 4};

    model_reset();
    @(negedge clk);
    check_zero("por");
    rst = 0;

    // directed table
    for (int i = 0; i < 15; i++) begin
      in_data = tbl[i].din; en = tbl[i].en; mode = tbl[i].mode; clear = 0;
      tick();
      chk($sformatf("tbl%0d_now", i), now, tbl[i].now);
      chk($sformatf("tbl%0d_prev", i), prev, tbl[i].prev);
      chk($sformatf("tbl%0d_pulse", i), edge_pulse, tbl[i].pulse);
      chk($sformatf("tbl%0d_sticky", i), edge_sticky, tbl[i].sticky);
      chk($sformatf("tbl%0d_count", i), edge_count, tbl[i].cnt);
    end

    // asynchronous reset mid-stream with inputs high
    @(posedge clk);
    #2 rst = 1; in_data = 8'hFF;
    #1 check_zero("arst");
    model_reset();
    @(negedge clk);
    in_data = '0; rst = 0;
    for (int i = 0; i < 4; i++) tick();
    check_zero("post_rst");

    // clear colliding with a channel-1 edge
    mode = 16'h5555; en = 1;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'h01; tick();
      in_data = 8'h00; tick();
    end
    tick(); tick();
    chk("pre_clr_sticky", edge_sticky, 8'h01);
    chk("pre_clr_count", edge_count, 5);
    in_data = 8'h02; tick(); tick();
    clear = 1; tick(); clear = 0;
    chk("clr_col_sticky", edge_sticky, 8'h02);
    chk("clr_col_count", edge_count, 1);

    // saturation: 20 edge cycles with both-edge mode
    mode = 16'hFFFF;
    for (int k = 0; k < 20; k++) begin
      in_data = ~in_data; tick();
    end
    tick(); tick(); tick();
    chk("sat_count", edge_count, 15);
    chk("sat_flag", count_sat, 1);
    clear = 1; tick(); clear = 0;
    chk("sat_clr_count", edge_count, 0);
    chk("sat_clr_flag", count_sat, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_data = W'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      clear   = ($urandom_range(0, 15) == 0);
      if (n % 16 == 0) mode = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
